// File: rtl/shift_pattern_decoder.sv
// Tracks a bouncing one-hot pattern (7..0..7) on q_in and flags any sample that breaks it.
// Optional tc counter enabled by defining SHIFT_PATTERN_DECODER_PERIOD_CNT_EN.
module shift_pattern_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] q_in,
  output logic [2:0] pos,
  output logic       dir,
  output logic       locked,
  output logic       tc,
  output logic [7:0] period_count,
  output logic       err,
  output logic       err_sticky
);

  typedef enum logic [1:0] {IDLE, ACQ, TRACK, FAULT} state_t;

  state_t     state, state_next;
  logic [2:0] pos_next;
  logic       dir_next;
  logic       tc_next;
  logic       err_next;

  logic       sample_legal;
  logic [2:0] sample_idx;
  logic       is_below;
  logic       is_above;
  logic       acq_match;
  logic       track_match;

  always_comb begin
    sample_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (q_in[i]) sample_idx = 3'(i);
    end
  end

  assign sample_legal = (q_in != 8'd0) && ((q_in & (q_in - 8'd1)) == 8'd0);

  // Adjacency is guarded at the ends so 0-1 and 7+1 never wrap into a false match.
  assign is_below    = (pos != 3'd0) && (sample_idx == pos - 3'd1);
  assign is_above    = (pos != 3'd7) && (sample_idx == pos + 3'd1);
  assign acq_match   = sample_legal && (is_below || is_above);
  assign track_match = sample_legal && (dir ? is_below : is_above);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pos        <= 3'd7;
      dir        <= 1'b1;
      locked     <= 1'b0;
      tc         <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state      <= state_next;
      pos        <= pos_next;
      dir        <= dir_next;
      locked     <= (state_next == TRACK);
      tc         <= tc_next;
      err        <= err_next;
      err_sticky <= err_sticky | err_next;
    end
  end

  always_comb begin
    state_next = state;
    if (ena) begin
      case (state)
        IDLE:    if (sample_legal) state_next = ACQ;
        ACQ:     state_next = acq_match ? TRACK : FAULT;
        TRACK:   if (!track_match) state_next = FAULT;
        FAULT:   if (sample_legal) state_next = ACQ;
        default: state_next = IDLE;
      endcase
    end
  end

  // Accepting an end position forces the bounce, overriding the observed direction.
  always_comb begin
    pos_next = pos;
    dir_next = dir;
    tc_next  = 1'b0;
    err_next = 1'b0;
    if (ena) begin
      case (state)
        IDLE, FAULT: begin
          if (sample_legal) pos_next = sample_idx;
          else              err_next = 1'b1;
        end
        ACQ, TRACK: begin
          if ((state == ACQ) ? acq_match : track_match) begin
            pos_next = sample_idx;
            if (state == ACQ) dir_next = is_below;
            if (sample_idx == 3'd0) begin
              dir_next = 1'b0;
              tc_next  = 1'b1;
            end else if (sample_idx == 3'd7) begin
              dir_next = 1'b1;
            end
          end else begin
            err_next = 1'b1;
          end
        end
        default: err_next = 1'b0;
      endcase
    end
  end

`ifdef SHIFT_PATTERN_DECODER_PERIOD_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)          period_count <= 8'd0;
    else if (tc_next) period_count <= period_count + 8'd1;
  end
`else
  assign period_count = 8'd0;
`endif

endmodule

// File: tb/tb_shift_pattern_decoder.sv
// Scoreboard bench for shift_pattern_decoder: driver queues expected responses, monitor compares each cycle.
module tb_shift_pattern_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [7:0] q_in = 8'h00;
  logic [2:0] pos;
  logic       dir;
  logic       locked;
  logic       tc;
  logic [7:0] period_count;
  logic       err;
  logic       err_sticky;

`ifdef SHIFT_PATTERN_DECODER_PERIOD_CNT_EN
  localparam bit PC_EN = 1'b1;
`else
  localparam bit PC_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] pos;
    logic       dir;
    logic       locked;
    logic       tc;
    logic [7:0] pc;
    logic       err;
    logic       sticky;
  } resp_t;

  resp_t expQ[$];
  int    checks   = 0;
  int    failures = 0;

  int mState  = 0;
  int mPos    = 7;
  int mDir    = 1;
  int mPc     = 0;
  bit mSticky = 1'b0;

  int sweep[15] = '{7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5, 6, 7};
  int tcSeen;

  shift_pattern_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .q_in         (q_in),
    .pos          (pos),
    .dir          (dir),
    .locked       (locked),
    .tc           (tc),
    .period_count (period_count),
    .err          (err),
    .err_sticky   (err_sticky)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the response expected after the next rising edge.
  task automatic applyStimulus(input bit r, input bit e, input logic [7:0] q);
    resp_t expR;
    bit    legal;
    bit    accept;
    bit    mErr;
    bit    mTc;
    int    idx;
    @(negedge clk);
    rst  = r;
    ena  = e;
    q_in = q;
    legal  = ($countones(q) == 1);
    accept = 1'b0;
    mErr   = 1'b0;
    mTc    = 1'b0;
    idx    = -10;
    for (int b = 0; b < 8; b++) if (q[b]) idx = b;
    if (r) begin
      mState = 0; mPos = 7; mDir = 1; mPc = 0; mSticky = 1'b0;
    end else if (e) begin
      case (mState)
        0, 3: begin
          if (legal) begin mPos = idx; mState = 1; end
          else mErr = 1'b1;
        end
        1: begin
          if (legal && (idx == mPos - 1 || idx == mPos + 1)) begin
            mDir = (idx == mPos - 1) ? 1 : 0;
            mPos = idx; mState = 2; accept = 1'b1;
          end else begin
            mErr = 1'b1; mState = 3;
          end
        end
        default: begin
          if (legal && idx == ((mDir == 1) ? mPos - 1 : mPos + 1)) begin
            mPos = idx; accept = 1'b1;
          end else begin
            mErr = 1'b1; mState = 3;
          end
        end
      endcase
      if (accept && mPos == 0) begin
        mDir = 0; mTc = 1'b1; mPc = (mPc + 1) % 256;
      end
      if (accept && mPos == 7) mDir = 1;
      mSticky = mSticky | mErr;
    end
    expR.pos    = 3'(mPos);
    expR.dir    = mDir[0];
    expR.locked = (mState == 2);
    expR.tc     = mTc;
    expR.pc     = PC_EN ? 8'(mPc) : 8'd0;
    expR.err    = mErr;
    expR.sticky = mSticky;
    expQ.push_back(expR);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    resp_t expR;
    resp_t act;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        expR = expQ.pop_front();
        act  = '{pos, dir, locked, tc, period_count, err, err_sticky};
        checks++;
        if (act !== expR) begin
          failures++;
          $display("[TB] FAIL scoreboard @%0t: got pos=%0d dir=%0b lk=%0b tc=%0b pc=%0d err=%0b st=%0b, wanted pos=%0d dir=%0b lk=%0b tc=%0b pc=%0d err=%0b st=%0b",
                   $time, act.pos, act.dir, act.locked, act.tc, act.pc, act.err, act.sticky,
                   expR.pos, expR.dir, expR.locked, expR.tc, expR.pc, expR.err, expR.sticky);
        end
      end
    end
  end

  initial begin : stimulus
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h55);
    settle();
    checkOutput("reset_pos", 8'(pos), 8'd7);
    checkOutput("reset_dir", 8'(dir), 8'd1);
    checkOutput("reset_locked", 8'(locked), 8'd0);
    checkOutput("reset_err", 8'(err), 8'd0);
    checkOutput("reset_sticky", 8'(err_sticky), 8'd0);

    applyStimulus(1'b0, 1'b1, 8'h80);
    applyStimulus(1'b0, 1'b1, 8'h40);
    settle();
    checkOutput("acq_locked", 8'(locked), 8'd1);
    applyStimulus(1'b0, 1'b1, 8'h20);
    settle();
    checkOutput("trk_pos5", 8'(pos), 8'd5);
    checkOutput("trk_dir", 8'(dir), 8'd1);
    checkOutput("trk_sticky", 8'(err_sticky), 8'd0);

    applyStimulus(1'b1, 1'b0, 8'h00);
    tcSeen = 0;
    for (int k = 0; k < 15; k++) begin
      applyStimulus(1'b0, 1'b1, 8'(1 << sweep[k]));
      settle();
      tcSeen += int'(tc);
      if (k == 7) checkOutput("sweep_dir_at0", 8'(dir), 8'd0);
    end
    checkOutput("sweep_dir_at7", 8'(dir), 8'd1);
    checkOutput("sweep_tc_count", 8'(tcSeen), 8'd1);
    checkOutput("sweep_pc", period_count, PC_EN ? 8'd1 : 8'd0);

    applyStimulus(1'b0, 1'b1, 8'h40);
    applyStimulus(1'b0, 1'b1, 8'h20);
    applyStimulus(1'b0, 1'b1, 8'h10);
    applyStimulus(1'b0, 1'b1, 8'h18);
    settle();
    checkOutput("mm_err", 8'(err), 8'd1);
    checkOutput("mm_sticky", 8'(err_sticky), 8'd1);
    checkOutput("mm_locked", 8'(locked), 8'd0);
    checkOutput("mm_pos", 8'(pos), 8'd4);
    applyStimulus(1'b0, 1'b1, 8'h04);
    settle();
    checkOutput("resync_locked", 8'(locked), 8'd0);
    applyStimulus(1'b0, 1'b1, 8'h02);
    settle();
    checkOutput("resync_dir", 8'(dir), 8'd1);
    checkOutput("resync_locked2", 8'(locked), 8'd1);
    checkOutput("resync_sticky", 8'(err_sticky), 8'd1);

    applyStimulus(1'b0, 1'b1, 8'h01);
    applyStimulus(1'b0, 1'b1, 8'h01);
    settle();
    checkOutput("rep_end_err", 8'(err), 8'd1);
    checkOutput("rep_end_locked", 8'(locked), 8'd0);

    applyStimulus(1'b0, 1'b1, 8'h01);
    applyStimulus(1'b0, 1'b1, 8'h02);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 1'b0, 8'($urandom));
      settle();
      checkOutput("hold_pos", 8'(pos), 8'd1);
      checkOutput("hold_err", 8'(err), 8'd0);
    end
    applyStimulus(1'b0, 1'b1, 8'h04);
    settle();
    checkOutput("hold_resume_pos", 8'(pos), 8'd2);

    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h03);
    applyStimulus(1'b0, 1'b1, 8'h10);
    applyStimulus(1'b0, 1'b1, 8'h10);
    applyStimulus(1'b0, 1'b1, 8'h02);
    applyStimulus(1'b0, 1'b1, 8'h08);
    applyStimulus(1'b0, 1'b0, 8'hFF);
    settle();
    checkOutput("idle_err_drop", 8'(err), 8'd0);

    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h80);
    for (int s = 0; s < 256; s++) begin
      for (int k = 1; k < 15; k++) applyStimulus(1'b0, 1'b1, 8'(1 << sweep[k]));
      if (s == 254) begin
        settle();
        checkOutput("wrap_pc255", period_count, PC_EN ? 8'd255 : 8'd0);
      end
    end
    settle();
    checkOutput("wrap_pc0", period_count, 8'd0);
    checkOutput("wrap_locked", 8'(locked), 8'd1);
    applyStimulus(1'b0, 1'b1, 8'h40);
    applyStimulus(1'b0, 1'b1, 8'h20);
    applyStimulus(1'b1, 1'b1, 8'h10);
    settle();
    checkOutput("rst_mid_pos", 8'(pos), 8'd7);
    checkOutput("rst_mid_dir", 8'(dir), 8'd1);
    checkOutput("rst_mid_locked", 8'(locked), 8'd0);
    checkOutput("rst_mid_tc", 8'(tc), 8'd0);
    checkOutput("rst_mid_pc", period_count, 8'd0);
    checkOutput("rst_mid_err", 8'(err), 8'd0);
    checkOutput("rst_mid_sticky", 8'(err_sticky), 8'd0);

    applyStimulus(1'b0, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("scoreboard_drain", 8'(expQ.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
